matmul_operand_fetch: RTL and testbench
=======================================

MATMUL_OPERAND_FETCH -- requirements
Module: matmul_operand_fetch

Interface
REQ-001 Parameter WIDTH, default 16: element width in bits, also the address port width.
REQ-002 Parameter CHUNK_SIZE, default 4: elements per memory word.
REQ-003 Parameter INNER_DIMENSION, default 8: columns of A and rows of B (N); it SHALL be a multiple of CHUNK_SIZE, otherwise elaboration SHALL fail.
REQ-004 Parameter OUTER_DIMENSION, default 6: columns of B (P).
REQ-005 Parameter ROWS_A, default 6: rows of A (M); K = INNER_DIMENSION/CHUNK_SIZE denotes chunks per dot product.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle request to fetch the full M x P x K operand sequence.
REQ-009 busy  out  1  high from the cycle after accepted start until done.
REQ-010 done  out  1  one-cycle pulse after the final beat is consumed.
REQ-011 counter_A  out  WIDTH  read address to A memory (row-major chunks).
REQ-012 counter_B  out  WIDTH  read address to B memory (column-major chunks).
REQ-013 data_A  in  WIDTH*CHUNK_SIZE  A memory registered read data, valid one cycle after address.
REQ-014 data_B  in  WIDTH*CHUNK_SIZE  B memory registered read data, same timing.
REQ-015 out_A, out_B  out  WIDTH*CHUNK_SIZE each  operand chunk pair to MAC.
REQ-016 out_valid  out  1  out_A/out_B/flags valid.
REQ-017 out_ready  in  1  consumer accepts beat when out_valid & out_ready.
REQ-018 first_k, last_k, last  out  1 each  beat is k==0, k==K-1, final beat of run.

Function
REQ-019 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after final address issued; DRAIN->IDLE when skid buffer empty and no read in flight, asserting done that cycle.
REQ-020 Loop order: i over 0..M-1 (outer), j over 0..P-1, k over 0..K-1 (inner); counter_A = i*K+k, counter_B = j*K+k.
REQ-021 Read issue is marked by an internal issue strobe; each issue's data SHALL be captured from data_A/data_B exactly one cycle later into a 2-entry skid FIFO with its k/last tags.
REQ-022 Issue SHALL occur in cycle t only if occupancy + in_flight - pop < 2, where pop = out_valid & out_ready in cycle t; addresses advance only on issue and otherwise hold.
REQ-023 With out_ready held high, throughput SHALL be one beat per cycle; first out_valid SHALL rise 2 cycles after start is sampled.
REQ-024 out_valid = FIFO non-empty; head beat and flags SHALL remain stable while out_valid & !out_ready.
REQ-025 Simultaneous capture and pop SHALL leave occupancy unchanged, with FIFO order preserved.
REQ-026 FIFO SHALL never overflow; an overflow is a design error flagged by a simulation assertion.
REQ-027 start while busy SHALL be ignored; done and start in the same cycle SHALL not restart (start ignored).
REQ-028 Exactly M*P*K beats per run; last asserted only on beat (M-1,P-1,K-1).
REQ-029 K==1 SHALL assert first_k and last_k on every beat.

Reset
REQ-030 On rst_n low: state IDLE; counters, occupancy, in-flight cleared; counter_A=counter_B=0; out_valid, busy, done, flags, out_A, out_B = 0.
REQ-031 Reset mid-run SHALL discard the in-flight read and FIFO contents; no beat SHALL appear until the next start after rst_n rises.

Verification
REQ-032 Defaults, ready always high, memories preloaded with address-tagged data: start -> 72 beats on consecutive cycles, first at start+2; beat 0 A addr 0 B addr 0, beat 1 A 1 B 1, beat 2 A 0 B 2, beat 12 A 2 B 0; done one cycle after beat 71 accepted.
REQ-033 Ready low cycles 3-7 of run: out_valid stays high, head beat unchanged, counter_A/B frozen after FIFO fills (2 beats); no beat lost or duplicated across 72.
REQ-034 Random 50% out_ready: received sequence equals golden i/j/k order; first_k on every 2nd beat from 0, last only on beat 71.
REQ-035 rst_n pulsed low at beat 30: outputs zero immediately (asynchronous); new start yields full 72-beat run from addr 0.
REQ-036 start held high for 200 cycles: exactly one run of 72 beats while busy; a second run starts only after done (start sampled in IDLE).
REQ-037 CHUNK_SIZE=8, INNER_DIMENSION=8 (K=1), M=2, P=3: 6 beats, every beat first_k=last_k=1, counter_A sequence 0,0,0,1,1,1.

Source files
------------

// File: rtl/matmul_operand_fetch_if.sv
// Operand stream from the fetch unit to the MAC array: one A/B chunk pair per beat,
// tagged with its position in the k loop and the end of the run.
interface matmul_operand_fetch_if #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 4
) ();
    logic [WIDTH*CHUNK_SIZE-1:0] out_A;
    logic [WIDTH*CHUNK_SIZE-1:0] out_B;
    logic                        out_valid;
    logic                        out_ready;
    logic                        first_k;
    logic                        last_k;
    logic                        last;

    modport master (output out_A, out_B, out_valid, first_k, last_k, last, input out_ready);
    modport slave  (input out_A, out_B, out_valid, first_k, last_k, last, output out_ready);
endinterface

// File: rtl/matmul_operand_fetch.sv
// Walks the i/j/k operand order of an M x P x K matrix product, issuing A/B memory reads
// and streaming the returned chunk pairs through a 2-entry skid buffer with loop tags.
module matmul_operand_fetch #(
    parameter int WIDTH           = 16,
    parameter int CHUNK_SIZE      = 4,
    parameter int INNER_DIMENSION = 8,
    parameter int OUTER_DIMENSION = 6,
    parameter int ROWS_A          = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            counter_A,
    output logic [WIDTH-1:0]            counter_B,
    input  logic [WIDTH*CHUNK_SIZE-1:0] data_A,
    input  logic [WIDTH*CHUNK_SIZE-1:0] data_B,
    matmul_operand_fetch_if.master      op
);
    localparam int K  = INNER_DIMENSION / CHUNK_SIZE;
    localparam int DW = WIDTH * CHUNK_SIZE;
    localparam int EW = 2 * DW + 3;
    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] K_LAST = WIDTH'(K - 1);
    localparam logic [WIDTH-1:0] P_LAST = WIDTH'(OUTER_DIMENSION - 1);
    localparam logic [WIDTH-1:0] M_LAST = WIDTH'(ROWS_A - 1);

    if ((INNER_DIMENSION % CHUNK_SIZE) != 0 || K < 1) begin : g_bad_inner_dimension
        $error("INNER_DIMENSION must be a non-zero multiple of CHUNK_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] i_r, j_r, k_r;
    logic             inflight_r;
    logic [2:0]       tag_r;        // {first_k, last_k, last} of the read in flight
    logic [1:0]       occ_r;
    logic [1:0]       occ_next_s;
    logic [EW-1:0]    head_r, tail_r, entry_s;
    logic             out_valid_r;
    logic [2:0]       pending_s;
    logic             pop_s, issue_s, last_issue_s, accept_s, drained_s;
    logic             k_wrap_s, j_wrap_s, i_wrap_s;

    assign pop_s        = out_valid_r & op.out_ready;
    assign pending_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s      = (state_r == RUN) && (pending_s < 3'd2);
    assign k_wrap_s     = (k_r == K_LAST);
    assign j_wrap_s     = (j_r == P_LAST);
    assign i_wrap_s     = (i_r == M_LAST);
    assign last_issue_s = issue_s & k_wrap_s & j_wrap_s & i_wrap_s;
    assign accept_s     = (state_r == IDLE) && start && !done;
    assign drained_s    = !inflight_r && ((occ_r == 2'd0) || ((occ_r == 2'd1) && pop_s));
    assign entry_s      = {data_A, data_B, tag_r};

    assign op.out_A     = head_r[EW-1 -: DW];
    assign op.out_B     = head_r[3 +: DW];
    assign op.first_k   = head_r[2];
    assign op.last_k    = head_r[1];
    assign op.last      = head_r[0];
    assign op.out_valid = out_valid_r;

    // Skid buffer occupancy after this cycle's capture and pop.
    always_comb begin
        occ_next_s = occ_r;
        case ({inflight_r, pop_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase
    end

    // Run control: start acceptance, end-of-issue and drain completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_issue_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Loop indices and read addresses; A steps back to the row start when k wraps within a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r       <= ZERO;
            j_r       <= ZERO;
            k_r       <= ZERO;
            counter_A <= ZERO;
            counter_B <= ZERO;
        end else if (issue_s) begin
            if (!k_wrap_s) begin
                k_r       <= k_r + ONE;
                counter_A <= counter_A + ONE;
                counter_B <= counter_B + ONE;
            end else begin
                k_r <= ZERO;
                if (!j_wrap_s) begin
                    j_r       <= j_r + ONE;
                    counter_A <= counter_A - K_LAST;
                    counter_B <= counter_B + ONE;
                end else begin
                    j_r       <= ZERO;
                    counter_B <= ZERO;
                    if (!i_wrap_s) begin
                        i_r       <= i_r + ONE;
                        counter_A <= counter_A + ONE;
                    end else begin
                        i_r       <= ZERO;
                        counter_A <= ZERO;
                    end
                end
            end
        end
    end

    // Tags travel alongside the read so they line up with data one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
            tag_r      <= 3'b000;
        end else begin
            inflight_r <= issue_s;
            tag_r      <= {(k_r == ZERO), k_wrap_s, (k_wrap_s & j_wrap_s & i_wrap_s)};
        end
    end

    // Two-entry skid buffer; head_r drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r      <= {EW{1'b0}};
            tail_r      <= {EW{1'b0}};
            occ_r       <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            occ_r       <= occ_next_s;
            out_valid_r <= (occ_next_s != 2'd0);
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r <= entry_s;
                    end else begin
                        tail_r <= entry_s;
                    end
                end
                2'b01: head_r <= tail_r;
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        head_r <= entry_s;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= entry_s;
                    end
                end
                default: head_r <= head_r;
            endcase
        end
    end

    matmul_operand_fetch_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (inflight_r),
        .pop     (pop_s),
        .occ     (occ_r)
    );
endmodule

// Skid buffer integrity checks for matmul_operand_fetch.
module matmul_operand_fetch_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       capture,
    input logic       pop,
    input logic [1:0] occ
);
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && !pop && (occ == 2'd2)));
endmodule

// File: tb/tb_matmul_operand_fetch.sv
// Randomized bench for matmul_operand_fetch: address-tagged memories feed the DUT and every
// beat is compared with the i/j/k order computed arithmetically from the loop rules.
module tb_matmul_operand_fetch;
    localparam int M = 6, P = 6, K = 2, TOTAL = M * P * K;
    localparam int M1 = 2, P1 = 3, TOTAL1 = M1 * P1;

    logic         clk = 1'b0;
    logic         rst_n, start, start1;
    logic         busy, done, busy1, done1;
    logic [15:0]  counter_A, counter_B, counter_A1, counter_B1;
    logic [63:0]  data_A, data_B;
    logic [127:0] data_A1, data_B1;
    int           errors = 0;
    int           checks = 0;

    matmul_operand_fetch_if #(.WIDTH(16), .CHUNK_SIZE(4)) op ();
    matmul_operand_fetch_if #(.WIDTH(16), .CHUNK_SIZE(8)) op1 ();

    matmul_operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .counter_A(counter_A), .counter_B(counter_B), .data_A(data_A), .data_B(data_B), .op(op)
    );

    matmul_operand_fetch #(.WIDTH(16), .CHUNK_SIZE(8), .INNER_DIMENSION(8),
                           .OUTER_DIMENSION(P1), .ROWS_A(M1)) dut_k1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .counter_A(counter_A1), .counter_B(counter_B1), .data_A(data_A1), .data_B(data_B1), .op(op1)
    );

    always #5 clk = ~clk;

    // Every element carries its memory (A/B), word address and lane index.
    function automatic logic [127:0] tag_word(input logic is_b, input int addr);
        logic [127:0] w;
        logic [15:0]  a16;
        a16 = 16'(addr);
        for (int e = 0; e < 8; e++) w[e*16 +: 16] = {(is_b ? 4'hB : 4'hA), a16[7:0], 4'(e)};
        return w;
    endfunction

    always @(posedge clk) begin
        data_A  <= 64'(tag_word(1'b0, int'(counter_A)));
        data_B  <= 64'(tag_word(1'b1, int'(counter_B)));
        data_A1 <= tag_word(1'b0, int'(counter_A1));
        data_B1 <= tag_word(1'b1, int'(counter_B1));
    end

    function automatic int g_a(input int n);
        return (n / (P * K)) * K + (n % K);
    endfunction

    function automatic int g_b(input int n);
        return ((n / K) % P) * K + (n % K);
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input int n);
        check_eq("beat_a", op.out_A, 128'(64'(tag_word(1'b0, g_a(n)))));
        check_eq("beat_b", op.out_B, 128'(64'(tag_word(1'b1, g_b(n)))));
        check_eq("beat_first_k", op.first_k, (n % K) == 0);
        check_eq("beat_last_k", op.last_k, (n % K) == K - 1);
        check_eq("beat_last", op.last, n == TOTAL - 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, op.out_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_cnt_a"}, counter_A, 0);
        check_eq({tag, "_cnt_b"}, counter_B, 0);
        check_eq({tag, "_out_a"}, op.out_A, 0);
        check_eq({tag, "_out_b"}, op.out_B, 0);
        check_eq({tag, "_flags"}, {op.first_k, op.last_k, op.last}, 0);
    endtask

    // Current sample point is run cycle 0 (first cycle after start was sampled).
    // mode 0: ready always high; 1: random ready; 2: ready low in run cycles 3..7.
    task automatic consume_run(input int mode, input int rst_at);
        int n = 0;
        int cyc = 0;
        int last_acc = -1;
        bit fin = 1'b0;
        bit rdy;
        while (!fin && cyc < 1000) begin
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = !(cyc >= 3 && cyc <= 7);
                default: rdy = 1'b1;
            endcase
            op.out_ready = rdy;
            if (mode == 0 && cyc < 2) check_eq("latency_valid_low", op.out_valid, 0);
            if (mode == 2 && cyc >= 4 && cyc <= 7) begin
                check_eq("stall_valid", op.out_valid, 1);
                check_eq("stall_cnt_a", counter_A, g_a(n + 2));
                check_eq("stall_cnt_b", counter_B, g_b(n + 2));
            end
            if (op.out_valid) begin
                if (n >= TOTAL) check_eq("extra_beat", n, TOTAL - 1);
                else check_beat(n);
                if (rdy) begin
                    if (mode == 0) check_eq("beat_cycle", cyc, n + 2);
                    last_acc = cyc;
                    n++;
                end
            end
            if (done) begin
                fin = 1'b1;
                check_eq("done_cycle", cyc, last_acc + 1);
                check_eq("beat_count", n, TOTAL);
            end else if (rst_at >= 0 && n == rst_at) begin
                #3 rst_n = 1'b0;
                #1;
                check_zero_outputs("async_rst");
                fin = 1'b1;
            end
            if (!fin) begin
                tick();
                cyc++;
            end
        end
        if (!fin) check_eq("run_timeout", 1, 0);
    endtask

    task automatic do_run(input int mode);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        consume_run(mode, -1);
        tick();
        check_eq("idle_after_done", busy, 0);
    endtask

    initial begin
        int n1;
        bit fin1;
        rst_n         = 1'b0;
        start         = 1'b0;
        start1        = 1'b0;
        op.out_ready  = 1'b0;
        op1.out_ready = 1'b1;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("idle_valid", op.out_valid, 0);

        do_run(0);
        do_run(2);
        do_run(1);
        do_run(1);

        // Reset in the middle of a run, then a clean run from address 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        consume_run(0, 30);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("post_rst_no_beat", op.out_valid, 0);
        end
        do_run(0);

        // start held high: one complete run, restart only after done.
        start = 1'b1;
        tick();
        check_eq("hold_busy", busy, 1);
        consume_run(0, -1);
        tick();
        check_eq("hold_idle_after_done", busy, 0);
        check_eq("hold_no_valid", op.out_valid, 0);
        tick();
        check_eq("hold_restart", busy, 1);
        start = 1'b0;
        consume_run(0, -1);
        repeat (2) tick();

        // K == 1 configuration.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n1 = 0;
        fin1 = 1'b0;
        for (int c = 0; c < 40 && !fin1; c++) begin
            if (op1.out_valid) begin
                check_eq("k1_a", op1.out_A, tag_word(1'b0, n1 / P1));
                check_eq("k1_b", op1.out_B, tag_word(1'b1, n1 % P1));
                check_eq("k1_first_k", op1.first_k, 1);
                check_eq("k1_last_k", op1.last_k, 1);
                check_eq("k1_last", op1.last, n1 == TOTAL1 - 1);
                n1++;
            end
            if (done1) begin
                fin1 = 1'b1;
                check_eq("k1_beat_count", n1, TOTAL1);
            end
            tick();
        end
        if (!fin1) check_eq("k1_timeout", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
